bl_serial_sub: RTL and testbench
================================

Name: bl_serial_sub

Overview:
Bit-serial ripple-borrow subtractor; the subtract-direction counterpart of the team's registered ripple-carry adder.
- Computes d = a - b - bin over WIDTH bits, one bit per clock, LSB first.
- Exposes the per-bit borrow vector, mirroring the adder's per-bit carry vector.
- Uses a start/busy/done handshake so it can sit behind a simple controller in the arithmetic datapath.

Parameters:
WIDTH, 4, operand/result width in bits (>= 2)

Ports:
clk    input   1      rising-edge clock
rst    input   1      synchronous reset, active-low (0 = reset, sampled on rising clk)
start  input   1      request; sampled only when ready=1
a      input   WIDTH  minuend, captured on accepted start
b      input   WIDTH  subtrahend, captured on accepted start
bin    input   1      borrow-in, captured on accepted start
ready  output  1      1 in IDLE or DONE (can accept start)
busy   output  1      1 while in RUN
done   output  1      one-cycle pulse; d/bo/bout valid
d      output  WIDTH  difference
bo     output  WIDTH  per-bit borrow-out vector; bo[i] = borrow out of bit i
bout   output  1      final borrow = bo[WIDTH-1] (1 => a < b+bin)

Behaviour:
- Reset (rst=0 at rising clk), overriding everything, including an operation in progress:
  - state=IDLE, bit index=0, captured operands=0.
  - d=0, bo=0, bout=0, done=0, busy=0, ready=1.
  - A partial result is discarded; no done pulse for the aborted operation.
- States: IDLE, RUN, DONE.
  - ready=1 in IDLE and DONE; busy=1 only in RUN; done=1 only in DONE.
- IDLE, start=1 at edge E0:
  - Capture a, b, bin; running borrow br <= bin.
  - Clear d and bo to 0; index <= 0; go to RUN.
- RUN, edge at index i (i = 0..WIDTH-1), with ai/bi from the captured operands:
  - d[i] <= ai ^ bi ^ br.
  - bo[i] <= (~ai & bi) | (~ai & br) | (bi & br).
  - br <= that same borrow value; index <= i+1.
  - Only bit i of d and bo changes on that edge.
- After bit WIDTH-1, go to DONE.
  - Edge E0+WIDTH computes the MSB and moves to DONE.
  - done=1 during the cycle after edge E0+WIDTH, i.e. latency WIDTH+1 cycles from start to done.
- DONE lasts exactly one cycle.
  - start=1 in DONE is accepted as if in IDLE: back-to-back operations with no bubble, done pulses spaced exactly WIDTH+1 cycles apart.
  - Otherwise DONE returns to IDLE.
- start while in RUN is ignored: no capture, no restart, no error flag. a/b/bin changes during RUN have no effect.
- d, bo and bout are stable from the done cycle until the next accepted start. They hold in IDLE indefinitely.
- Arithmetic:
  - d equals (a - b - bin) mod 2^WIDTH.
  - bout=1 exactly when unsigned a < b + bin.
  - {bout,d} read as two's complement over WIDTH+1 bits equals a - b - bin.
- bout is combinationally bo[WIDTH-1]; all other outputs are registered.
- Index counter width is ceil(log2(WIDTH+1)); it never wraps beyond WIDTH-1 in RUN.

Test Plan:
- Reset mid-operation: start a=5 b=3, pull rst=0 on 2nd RUN cycle -> next cycle d=0, bo=0, busy=0, ready=1; no done pulse; a new start then completes normally.
- Basic, WIDTH=4: a=4'b0101 b=4'b0011 bin=0 -> done exactly 5 cycles after start; d=4'b0010, bo=4'b0010, bout=0; busy=1 for 4 cycles.
- Negative result: a=3 b=5 bin=0 -> d=4'b1110, bo=4'b1100, bout=1.
- Borrow-in ripple: a=0 b=0 bin=1 -> d=4'b1111, bo=4'b1111, bout=1.
- Handshake edges:
  - start held continuously with a=9 b=9 bin=0 then a=7 b=2 -> first done d=0, bo=0.
  - Second start accepted in the DONE cycle, done again 5 cycles later with d=5, bout=0.
  - start pulses during RUN are ignored.
- Exhaustive: all a, b in 0..15, bin in {0,1}, run back-to-back -> every {bout,d} matches the reference model a-b-bin. Repeat with WIDTH=8 on random vectors.

Source files
------------

// File: rtl/bl_serial_sub_if.sv
// rtl/bl_serial_sub_if.sv - handshake and operand/result bundle for the bit-serial subtractor
interface bl_serial_sub_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] bo;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  ready, busy, done, d, bo, bout
  );

  modport slave (
    input  start, a, b, bin,
    output ready, busy, done, d, bo, bout
  );
endinterface

// File: rtl/bl_serial_sub.sv
// rtl/bl_serial_sub.sv - bit-serial ripple-borrow subtractor, LSB first, start/busy/done handshake
module bl_serial_sub #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  bl_serial_sub_if.slave bus
);
  localparam int IW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] bo_q;
  logic             br;
  logic             accept;
  logic             last;
  logic             bit_d;
  logic             bit_b;

  // Operands are shifted right each RUN cycle so the current bit always sits at [0].
  assign accept = (state != RUN) && bus.start;
  assign last   = (idx == IW'(WIDTH - 1));
  assign bit_d  = a_sh[0] ^ b_sh[0] ^ br;
  assign bit_b  = (~a_sh[0] & b_sh[0]) | (~a_sh[0] & br) | (b_sh[0] & br);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state: DONE behaves like IDLE for start, giving bubble-free back-to-back operations.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture on accepted start, then resolve one difference/borrow bit per RUN cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_sh <= '0;
      b_sh <= '0;
      br   <= 1'b0;
      d_q  <= '0;
      bo_q <= '0;
      idx  <= '0;
    end else if (accept) begin
      a_sh <= bus.a;
      b_sh <= bus.b;
      br   <= bus.bin;
      d_q  <= '0;
      bo_q <= '0;
      idx  <= '0;
    end else if (state == RUN) begin
      for (int k = 0; k < WIDTH; k++) begin
        if (idx == IW'(k)) begin
          d_q[k]  <= bit_d;
          bo_q[k] <= bit_b;
        end
      end
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      br   <= bit_b;
      idx  <= idx + IW'(1);
    end
  end

  assign bus.ready = (state != RUN);
  assign bus.busy  = (state == RUN);
  assign bus.done  = (state == DONE);
  assign bus.d     = d_q;
  assign bus.bo    = bo_q;
  assign bus.bout  = bo_q[WIDTH-1];
endmodule

// File: tb/tb_bl_serial_sub.sv
// tb/tb_bl_serial_sub.sv - directed and table-driven bench for bl_serial_sub (WIDTH 4 and 8)
module tb_bl_serial_sub;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bl_serial_sub_if #(.WIDTH(4)) bus4();
  bl_serial_sub_if #(.WIDTH(8)) bus8();

  bl_serial_sub #(.WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus4.slave)
  );

  bl_serial_sub #(.WIDTH(8)) dut8 (
    .clk(clk),
    .rst(rst),
    .bus(bus8.slave)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] d;
    logic [3:0] bo;
    logic       bout;
  } vec_t;

  vec_t vt[8];
  int   nvec = 0;
  int   nfail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic timeout(input string nm);
    nvec++;
    nfail++;
    $display("FAIL %s: done never seen, required within 20 cycles", nm);
  endtask

  task automatic wait_done4(output int cyc);
    cyc = 0;
    while (bus4.done !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    if (cyc >= 20) timeout("wait_done4");
  endtask

  task automatic wait_done8(output int cyc);
    cyc = 0;
    while (bus8.done !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    if (cyc >= 20) timeout("wait_done8");
  endtask

  // Borrow out of bit i is set exactly when the low i+1 bits of a are below those of b plus bin.
  function automatic logic [7:0] ref_bo(input int w, input int a, input int b, input int bin);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      int m;
      m = (1 << (i + 1)) - 1;
      r[i] = ((a & m) < ((b & m) + bin));
    end
    return r;
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    int cyc;
    int nb;
    bus4.a = v.a;
    bus4.b = v.b;
    bus4.bin = v.bin;
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    cyc = 0;
    nb = 0;
    while (bus4.done !== 1'b1 && cyc < 20) begin
      if (bus4.busy === 1'b1) nb++;
      tick();
      cyc++;
    end
    if (cyc >= 20) timeout({nm, "_timeout"});
    chk({nm, "_latency"}, cyc + 1, 5);
    chk({nm, "_busy_cycles"}, nb, 4);
    chk({nm, "_d"}, bus4.d, v.d);
    chk({nm, "_bo"}, bus4.bo, v.bo);
    chk({nm, "_bout"}, bus4.bout, v.bout);
    chk({nm, "_ready_in_done"}, bus4.ready, 1);
    tick();
    chk({nm, "_done_one_cycle"}, bus4.done, 0);
    chk({nm, "_d_held"}, bus4.d, v.d);
  endtask

  initial begin
    int cyc;
    int seen;
    int ea, eb, ebin, na, nb2, nbin;
    int ra[40];
    int rb[40];
    int rbin[40];

    vt[0] = '{4'd5,  4'd3,  1'b0, 4'b0010, 4'b0010, 1'b0};
    vt[1] = '{4'd3,  4'd5,  1'b0, 4'b1110, 4'b1100, 1'b1};
    vt[2] = '{4'd0,  4'd0,  1'b1, 4'b1111, 4'b1111, 1'b1};
    vt[3] = '{4'd9,  4'd9,  1'b0, 4'b0000, 4'b0000, 1'b0};
    vt[4] = '{4'd7,  4'd2,  1'b0, 4'b0101, 4'b0000, 1'b0};
    vt[5] = '{4'd15, 4'd0,  1'b1, 4'b1110, 4'b0000, 1'b0};
    vt[6] = '{4'd0,  4'd15, 1'b0, 4'b0001, 4'b1111, 1'b1};
    vt[7] = '{4'd8,  4'd1,  1'b1, 4'b0110, 4'b0111, 1'b0};

    rst = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.bin = 1'b0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
    tick();
    tick();
    chk("rst_ready", bus4.ready, 1);
    chk("rst_busy", bus4.busy, 0);
    chk("rst_done", bus4.done, 0);
    chk("rst_d", bus4.d, 0);
    chk("rst_bo", bus4.bo, 0);
    chk("rst_bout", bus4.bout, 0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Reset during the second RUN cycle discards the partial result.
    bus4.a = 4'd5; bus4.b = 4'd3; bus4.bin = 1'b0; bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_d", bus4.d, 0);
    chk("midrst_bo", bus4.bo, 0);
    chk("midrst_busy", bus4.busy, 0);
    chk("midrst_ready", bus4.ready, 1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus4.done === 1'b1) seen++;
      tick();
    end
    chk("midrst_no_done", seen, 0);
    run_vec(vt[0], "after_rst");

    // Start held through RUN with changing operands, then accepted again in DONE.
    bus4.a = 4'd9; bus4.b = 4'd9; bus4.bin = 1'b0; bus4.start = 1'b1;
    tick();
    bus4.a = 4'd7; bus4.b = 4'd2;
    wait_done4(cyc);
    chk("b2b_first_d", bus4.d, 0);
    chk("b2b_first_bo", bus4.bo, 0);
    chk("b2b_first_bout", bus4.bout, 0);
    tick();
    bus4.start = 1'b0;
    chk("b2b_accept_in_done", bus4.busy, 1);
    bus4.a = 4'd1; bus4.b = 4'd14; bus4.bin = 1'b1;
    tick();
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    wait_done4(cyc);
    chk("b2b_spacing", cyc + 3, 5);
    chk("b2b_second_d", bus4.d, 5);
    chk("b2b_second_bout", bus4.bout, 0);
    tick();
    chk("b2b_idle_ready", bus4.ready, 1);
    chk("b2b_idle_done", bus4.done, 0);
    tick();
    tick();
    tick();
    chk("b2b_hold_d", bus4.d, 5);

    // Exhaustive WIDTH=4, all operations chained back-to-back.
    bus4.a = '0; bus4.b = '0; bus4.bin = 1'b0; bus4.start = 1'b1;
    tick();
    for (int n = 0; n < 512; n++) begin
      ea = (n >> 5) & 15;
      eb = (n >> 1) & 15;
      ebin = n & 1;
      if (n < 511) begin
        na = ((n + 1) >> 5) & 15;
        nb2 = ((n + 1) >> 1) & 15;
        nbin = (n + 1) & 1;
        bus4.a = 4'(na); bus4.b = 4'(nb2); bus4.bin = 1'(nbin);
      end else begin
        bus4.start = 1'b0;
      end
      wait_done4(cyc);
      chk($sformatf("ex4_res_%0d_%0d_%0d", ea, eb, ebin), {bus4.bout, bus4.d}, (ea - eb - ebin) & 31);
      chk($sformatf("ex4_bo_%0d_%0d_%0d", ea, eb, ebin), bus4.bo, ref_bo(4, ea, eb, ebin));
      chk("ex4_gap", cyc, 4);
      tick();
    end

    // WIDTH=8 random vectors, chained back-to-back, with the extreme borrow case first.
    ra[0] = 0; rb[0] = 255; rbin[0] = 1;
    ra[1] = 255; rb[1] = 255; rbin[1] = 0;
    for (int i = 2; i < 40; i++) begin
      ra[i] = int'($urandom_range(0, 255));
      rb[i] = int'($urandom_range(0, 255));
      rbin[i] = int'($urandom_range(0, 1));
    end
    bus8.a = 8'(ra[0]); bus8.b = 8'(rb[0]); bus8.bin = 1'(rbin[0]); bus8.start = 1'b1;
    tick();
    for (int n = 0; n < 40; n++) begin
      if (n < 39) begin
        bus8.a = 8'(ra[n + 1]); bus8.b = 8'(rb[n + 1]); bus8.bin = 1'(rbin[n + 1]);
      end else begin
        bus8.start = 1'b0;
      end
      wait_done8(cyc);
      chk($sformatf("w8_res_%0d_%0d_%0d", ra[n], rb[n], rbin[n]), {bus8.bout, bus8.d},
          (ra[n] - rb[n] - rbin[n]) & 511);
      chk($sformatf("w8_bo_%0d_%0d_%0d", ra[n], rb[n], rbin[n]), bus8.bo,
          ref_bo(8, ra[n], rb[n], rbin[n]));
      chk("w8_gap", cyc, 8);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
